// File: rtl/adder_operand_collector_if.sv
// Handshake bundle between the word source, the collector and the adder.
// Ports: in_valid/in_ready/in_data (word stream in),
//        a/b/cin/op_valid/op_ready (operand set out),
//        op_count/bad_cin (status).
interface adder_operand_collector_if #(
  parameter int DATA_LEN = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_data;
  logic [DATA_LEN-1:0] a;
  logic [DATA_LEN-1:0] b;
  logic                cin;
  logic                op_valid;
  logic                op_ready;
  logic [7:0]          op_count;
  logic                bad_cin;

  modport slave (
    input  in_valid,
    input  in_data,
    input  op_ready,
    output in_ready,
    output a,
    output b,
    output cin,
    output op_valid,
    output op_count,
    output bad_cin
  );

  modport master (
    output in_valid,
    output in_data,
    output op_ready,
    input  in_ready,
    input  a,
    input  b,
    input  cin,
    input  op_valid,
    input  op_count,
    input  bad_cin
  );
endinterface

// File: rtl/adder_operand_collector.sv
// Assembles a, b and carry words from a serial stream into one
// registered operand set and hands it to the adder stage.
// Ports: clk, rst (async, active high), clear (sync flush),
//        bus (slave side of adder_operand_collector_if).
module adder_operand_collector #(
  parameter int DATA_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  adder_operand_collector_if.slave bus
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    GET_C = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_LEN-1:0] a_q;
  logic [DATA_LEN-1:0] a_nxt;
  logic [DATA_LEN-1:0] b_q;
  logic [DATA_LEN-1:0] b_nxt;
  logic                cin_q;
  logic                cin_nxt;
  logic                bad_q;
  logic                bad_nxt;
  logic [7:0]          cnt_q;
  logic [7:0]          cnt_nxt;

  logic in_rdy;
  logic op_vld;
  logic accept;
  logic handoff;
  logic hi_bits;

  // Handshake flags come from state only, never from the inputs.
  assign in_rdy  = (state != HOLD);
  assign op_vld  = (state == HOLD);
  assign accept  = bus.in_valid & in_rdy;
  assign handoff = bus.op_ready & op_vld;

  // A carry word must only use bit 0.
  assign hi_bits = |bus.in_data[DATA_LEN-1:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      bad_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      cin_q <= cin_nxt;
      bad_q <= bad_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    cin_nxt   = cin_q;
    bad_nxt   = bad_q;
    cnt_nxt   = cnt_q;

    unique case (state)
      GET_A: begin
        if (accept) begin
          a_nxt     = bus.in_data;
          state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (accept) begin
          b_nxt     = bus.in_data;
          state_nxt = GET_C;
        end
      end
      GET_C: begin
        if (accept) begin
          cin_nxt   = bus.in_data[0];
          bad_nxt   = bad_q | hi_bits;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (handoff) begin
          cnt_nxt   = cnt_q + 8'd1;
          state_nxt = GET_A;
        end
      end
      default: state_nxt = GET_A;
    endcase

    // Flush drops any word or handoff in flight this cycle.
    if (clear) begin
      state_nxt = GET_A;
      a_nxt     = '0;
      b_nxt     = '0;
      cin_nxt   = 1'b0;
      bad_nxt   = 1'b0;
      cnt_nxt   = 8'd0;
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.op_valid = op_vld;
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.cin      = cin_q;
  assign bus.bad_cin  = bad_q;
  assign bus.op_count = cnt_q;

endmodule

// File: tb/tb_adder_operand_collector.sv
// Directed bench for adder_operand_collector.
// Drives words through the interface and checks outputs 1ns after edges.
module tb_adder_operand_collector;

  logic clk;
  logic rst;
  logic clear;
  int   total;
  int   bad;

  adder_operand_collector_if #(.DATA_LEN(8)) bus ();

  adder_operand_collector #(.DATA_LEN(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hA5;
  endtask

  task automatic send3(
    input logic [7:0] wa,
    input logic [7:0] wb,
    input logic [7:0] wc
  );
    word(wa);
    word(wb);
    word(wc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.op_ready = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_a", bus.a, 0);
    chk("rst_b", bus.b, 0);
    chk("rst_cin", bus.cin, 0);
    chk("rst_count", bus.op_count, 0);
    chk("rst_bad", bus.bad_cin, 0);
    rst = 1'b0;
    tick();

    // basic set, op_ready high
    bus.op_ready = 1'b1;
    word(8'h12);
    chk("t1_a", bus.a, 8'h12);
    chk("t1_vld_e1", bus.op_valid, 0);
    word(8'h34);
    chk("t1_b", bus.b, 8'h34);
    chk("t1_vld_e2", bus.op_valid, 0);
    word(8'h01);
    chk("t1_vld_e3", bus.op_valid, 1);
    chk("t1_rdy_e3", bus.in_ready, 0);
    chk("t1_cin", bus.cin, 1);
    tick();
    chk("t1_vld_e4", bus.op_valid, 0);
    chk("t1_rdy_e4", bus.in_ready, 1);
    chk("t1_count", bus.op_count, 1);
    chk("t1_a_kept", bus.a, 8'h12);

    // backpressure
    bus.op_ready = 1'b0;
    send3(8'h12, 8'h34, 8'h01);
    for (int i = 0; i < 10; i++) begin
      chk("t2_vld", bus.op_valid, 1);
      chk("t2_rdy", bus.in_ready, 0);
      chk("t2_abc", {bus.a, bus.b, 7'd0, bus.cin}, 24'h123401);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h77;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("t2_abc_end", {bus.a, bus.b, 7'd0, bus.cin}, 24'h123401);
    bus.op_ready = 1'b1;
    tick();
    chk("t2_rdy_after", bus.in_ready, 1);
    chk("t2_count", bus.op_count, 2);

    // gapped input with junk on idle cycles
    word(8'hFF);
    bus.in_data = 8'h3C;
    tick();
    bus.in_data = 8'hC3;
    tick();
    chk("t3_a_idle", bus.a, 8'hFF);
    chk("t3_b_idle", bus.b, 8'h34);
    word(8'hFF);
    bus.in_data = 8'h5A;
    tick();
    chk("t3_vld_idle", bus.op_valid, 0);
    word(8'h00);
    chk("t3_vld", bus.op_valid, 1);
    chk("t3_abc", {bus.a, bus.b, 7'd0, bus.cin}, 24'hFFFF00);
    tick();
    chk("t3_count", bus.op_count, 3);

    // bad carry word, sticky flag, clear
    send3(8'h05, 8'h06, 8'h03);
    chk("t4_cin", bus.cin, 1);
    chk("t4_bad", bus.bad_cin, 1);
    tick();
    send3(8'h07, 8'h08, 8'h00);
    chk("t4_cin0", bus.cin, 0);
    chk("t4_bad_sticky", bus.bad_cin, 1);
    tick();
    chk("t4_count", bus.op_count, 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_bad_clr", bus.bad_cin, 0);
    chk("t4_count_clr", bus.op_count, 0);
    chk("t4_a_clr", bus.a, 0);

    // clear with accept in GET_C
    word(8'h44);
    word(8'h55);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    clear        = 1'b1;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_vld", bus.op_valid, 0);
    chk("t5_rdy", bus.in_ready, 1);
    chk("t5_abc", {bus.a, bus.b, 7'd0, bus.cin}, 24'h000000);
    tick();
    chk("t5_vld2", bus.op_valid, 0);
    send3(8'h21, 8'h22, 8'h01);
    chk("t5_vld3", bus.op_valid, 1);
    chk("t5_abc2", {bus.a, bus.b, 7'd0, bus.cin}, 24'h212201);
    tick();
    chk("t5_count", bus.op_count, 1);

    // count wrap over 256 sets
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send3(i[7:0], 8'h10, 8'h00);
      tick();
      if (i == 254)
        chk("t6_count255", bus.op_count, 255);
    end
    chk("t6_wrap", bus.op_count, 0);

    // async reset mid-cycle while in GET_B
    word(8'h55);
    chk("t7_a", bus.a, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rdy", bus.in_ready, 1);
    chk("t7_vld", bus.op_valid, 0);
    chk("t7_a_rst", bus.a, 0);
    #1;
    rst = 1'b0;
    tick();
    word(8'h66);
    chk("t7_a_new", bus.a, 8'h66);
    chk("t7_b_new", bus.b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
